lpf_seq: RTL and testbench
==========================

Name: lpf_seq

Overview:
- Initiator and sequencer for the 32-bit single-step low-pass filter datapath (`lpf`).
- Accepts input samples over a valid/ready stream and owns the filter state y.
- For each sample it drives x, y_ex and k to the filter, pulses the start strobe, waits the fixed filter latency, then captures y.
- Presents the result on an output valid/ready stream and feeds it back as the next y_ex.

Parameters:
- WIDTH, 32, data width of x, y and k.
- LPF_LAT, 3, filter latency: number of WAIT cycles after the start-pulse cycle before y is valid. Legal range 1..15.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- cfg_k  in  WIDTH  filter coefficient; sampled on sample accept.
- init_en  in  1  load filter state from init_val; honoured only in IDLE.
- init_val  in  WIDTH  initial y state.
- s_valid  in  1  input sample valid.
- s_ready  out  1  sequencer can accept a sample.
- s_data  in  WIDTH  input sample x.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_data  out  WIDTH  filtered result y.
- lpf_sta  out  1  start strobe to the filter; one-cycle pulse.
- lpf_x  out  WIDTH  x to the filter.
- lpf_y_ex  out  WIDTH  previous y to the filter.
- lpf_k  out  WIDTH  coefficient to the filter.
- lpf_y  in  WIDTH  filter result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release) clears the following to 0, and the FSM goes to IDLE:
  - y_state, x_reg, k_reg, m_data, wait counter.
  - lpf_sta, m_valid, busy.
  - s_ready is 1 after reset.
- FSM states are IDLE, START, WAIT and OUT.
- IDLE:
  - s_ready=1.
  - On s_valid&s_ready: x_reg<=s_data, k_reg<=cfg_k, go to START.
  - Else if init_en: y_state<=init_val, stay in IDLE.
  - If s_valid and init_en are both high in the same cycle, the sample wins and init_en is dropped.
- START:
  - One cycle, with lpf_sta=1.
  - Counter loaded with LPF_LAT-1.
  - Go to WAIT.
- WAIT:
  - lpf_sta=0.
  - Counter decrements each cycle.
  - In the cycle where counter==0: y_state<=lpf_y, m_data<=lpf_y, go to OUT.
- OUT:
  - m_valid=1.
  - On m_ready go to IDLE, with m_valid dropping the next cycle.
  - m_data is held stable while m_valid&!m_ready.
- Outside IDLE:
  - s_ready=0.
  - init_en is ignored; it is not queued.
- Filter interface outputs:
  - lpf_x=x_reg, lpf_y_ex=y_state, lpf_k=k_reg; all registered.
  - They are stable from START through the end of WAIT.
  - They do not change until the next accept.
- Latency:
  - Sample accepted at edge 0.
  - lpf_sta high during cycle 1.
  - m_valid high from cycle 2+LPF_LAT.
  - Minimum accept-to-accept period is LPF_LAT+3 cycles when m_ready is held high.
- Arithmetic: none in this block. Values pass through unmodified; any wrap-around is the filter's concern.
- Reset mid-operation (any state):
  - Immediate return to IDLE with all registers at 0.
  - The in-flight result is discarded.
  - lpf_sta deasserts immediately.
- cfg_k changing while busy does not affect the current operation.

Decomposition:
- Shared package `lpf_pkg` holds:
  - FSM state encoding (2-bit: IDLE=0, START=1, WAIT=2, OUT=3).
  - Default WIDTH and LPF_LAT constants.
- No sub-module. The wait counter stays inline, 4 bits wide.
- Top-level integration instantiates `lpf_seq` beside `lpf`.

Test Plan:
- Bench uses a behavioural filter model: y = y_ex + (((x−y_ex)*k)>>>16), valid LPF_LAT cycles after the lpf_sta cycle.
- Init and two samples, k=0x00008000:
  - init_en with init_val=0, then s_data=0x00000100 → m_data=0x00000080.
  - Second s_data=0x00000100 → m_data=0x000000C0.
  - Check lpf_y_ex=0x80 during the second operation.
- Latency, LPF_LAT=3, m_ready=1:
  - Accept at cycle 0 → lpf_sta high only in cycle 1, m_valid first high in cycle 5.
  - s_ready low in cycles 1–5, high again in cycle 6.
- Backpressure:
  - m_ready=0 for 5 cycles in OUT → m_valid stays 1 and m_data stays constant.
  - s_ready stays 0 and s_valid pulses are not accepted.
  - Result consumed when m_ready=1.
- init_en mid-operation:
  - Assert init_en with init_val=0x1234 during WAIT → ignored.
  - Next operation's lpf_y_ex equals the previous result, not 0x1234.
  - s_valid and init_en together in IDLE → sample accepted, y_state unchanged by init.
- Reset during WAIT:
  - Assert rst for 2 cycles mid-WAIT → busy, m_valid and lpf_sta are 0, s_ready=1, y_state=0.
  - Next sample x=0x100, k=0x8000 → m_data=0x80.
- cfg_k change while busy:
  - Change cfg_k from 0x8000 to 0x4000 during WAIT → current result uses 0x8000 (lpf_k stable).
  - The next operation uses 0x4000.

Source files
------------

// File: rtl/lpf_pkg.sv
// Shared definitions for the low-pass filter sequencer:
// FSM state encoding and default datapath sizing.
package lpf_pkg;

    localparam int unsigned LPF_WIDTH   = 32;
    localparam int unsigned LPF_LAT_DEF = 3;
    localparam int unsigned LPF_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } lpf_state_e;

endpackage

// File: rtl/lpf_seq.sv
// Sequencer for the single-step low-pass filter: accepts samples,
// strobes the filter, waits its latency and returns y downstream.
module lpf_seq
    import lpf_pkg::*;
#(
    parameter int unsigned WIDTH   = LPF_WIDTH,
    parameter int unsigned LPF_LAT = LPF_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cfg_k,
    input  logic             init_en,
    input  logic [WIDTH-1:0] init_val,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             lpf_sta,
    output logic [WIDTH-1:0] lpf_x,
    output logic [WIDTH-1:0] lpf_y_ex,
    output logic [WIDTH-1:0] lpf_k,
    input  logic [WIDTH-1:0] lpf_y,
    output logic             busy
);

    localparam logic [LPF_CNT_W-1:0] CNT_LOAD = LPF_CNT_W'(LPF_LAT - 1);

    lpf_state_e           state_q, state_d;
    logic [LPF_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [WIDTH-1:0]     k_q, k_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic [WIDTH-1:0]     mdata_q, mdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            k_q     <= '0;
            y_q     <= '0;
            mdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            k_q     <= k_d;
            y_q     <= y_d;
            mdata_q <= mdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        k_d     = k_q;
        y_d     = y_q;
        mdata_d = mdata_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        lpf_sta = 1'b0;
        busy    = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                // A sample in the same cycle as init_en wins; init is dropped
                if (s_valid) begin
                    x_d     = s_data;
                    k_d     = cfg_k;
                    state_d = ST_START;
                end else if (init_en) begin
                    y_d = init_val;
                end
            end
            ST_START: begin
                lpf_sta = 1'b1;
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    y_d     = lpf_y;
                    mdata_d = lpf_y;
                    state_d = ST_OUT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign lpf_x    = x_q;
    assign lpf_y_ex = y_q;
    assign lpf_k    = k_q;
    assign m_data   = mdata_q;

endmodule

// File: tb/tb_lpf_seq.sv
// Directed bench for lpf_seq with a behavioural filter model and
// a result scoreboard drained by an independent monitor.
module tb_lpf_seq;

    localparam int W   = 32;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] cfg_k;
    logic         init_en;
    logic [W-1:0] init_val;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         lpf_sta;
    logic [W-1:0] lpf_x;
    logic [W-1:0] lpf_y_ex;
    logic [W-1:0] lpf_k;
    logic [W-1:0] lpf_y;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    lpf_seq #(.WIDTH(W), .LPF_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .cfg_k(cfg_k),
        .init_en(init_en), .init_val(init_val),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .lpf_sta(lpf_sta), .lpf_x(lpf_x), .lpf_y_ex(lpf_y_ex),
        .lpf_k(lpf_k), .lpf_y(lpf_y), .busy(busy)
    );

    // Behavioural filter: result appears LAT cycles after the strobe cycle
    logic [W-1:0] f_pend;
    int           f_cnt = 0;
    always @(posedge clk) begin
        logic signed [W-1:0]   diff;
        logic signed [2*W-1:0] prod;
        if (lpf_sta) begin
            diff   = $signed(lpf_x - lpf_y_ex);
            prod   = (diff * $signed(lpf_k)) >>> 16;
            f_pend = lpf_y_ex + prod[W-1:0];
            f_cnt  = LAT - 1;
            lpf_y  = 32'hDEADBEEF;
        end else if (f_cnt > 0) begin
            f_cnt = f_cnt - 1;
            if (f_cnt == 0) lpf_y = f_pend;
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compare every completed output handshake with the queue
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", m_data, 32'hFFFFFFFF);
            end else begin
                chk("m_data", m_data, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for s_ready, presents one sample; returns during the START cycle
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] k,
                         input logic [W-1:0] exp, input logic with_init);
        int t = 0;
        while (!s_ready && t < 50) begin
            step();
            t++;
        end
        if (!s_ready) begin
            chk("s_ready_timeout", 32'(s_ready), 32'd1);
        end
        s_valid = 1'b1;
        s_data  = x;
        cfg_k   = k;
        if (with_init) init_en = 1'b1;
        exp_q.push_back(exp);
        step();
        s_valid = 1'b0;
        init_en = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || !s_ready) && t < 100) begin
            step();
            t++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        cfg_k    = '0;
        init_en  = 1'b0;
        init_val = '0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b1;
        lpf_y    = '0;
        step();
        step();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_lpf_sta", 32'(lpf_sta), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_y_state", lpf_y_ex, 32'd0);
        rst = 1'b0;
        step();

        // Init then two samples with k = 0.5
        init_en  = 1'b1;
        init_val = 32'h0;
        step();
        init_en = 1'b0;
        issue(32'h100, 32'h8000, 32'h80, 1'b0);
        drain();
        issue(32'h100, 32'h8000, 32'hC0, 1'b0);
        @(negedge clk);
        chk("y_ex_second", lpf_y_ex, 32'h80);
        drain();

        // Latency profile, cycle 1 is the START cycle
        issue(32'h100, 32'h8000, 32'hE0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("lat_sta_c%0d", c), 32'(lpf_sta), 32'(c == 1));
            chk($sformatf("lat_mv_c%0d", c), 32'(m_valid), 32'(c == 5));
            chk($sformatf("lat_srdy_c%0d", c), 32'(s_ready), 32'(c == 6));
        end
        drain();

        // Backpressure in OUT
        m_ready = 1'b0;
        issue(32'h100, 32'h8000, 32'hF0, 1'b0);
        for (int c = 0; c < 4; c++) step();
        for (int c = 0; c < 5; c++) begin
            s_valid = c[0];
            s_data  = 32'h5555;
            @(negedge clk);
            chk("bp_m_valid", 32'(m_valid), 32'd1);
            chk("bp_m_data", m_data, 32'hF0);
            chk("bp_s_ready", 32'(s_ready), 32'd0);
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        drain();

        // init_en during WAIT is ignored
        issue(32'h200, 32'h8000, 32'h178, 1'b0);
        step();
        init_en  = 1'b1;
        init_val = 32'h1234;
        step();
        step();
        init_en = 1'b0;
        drain();
        issue(32'h178, 32'h8000, 32'h178, 1'b0);
        @(negedge clk);
        chk("y_ex_after_init_wait", lpf_y_ex, 32'h178);
        drain();
        issue(32'h378, 32'h8000, 32'h278, 1'b1);
        @(negedge clk);
        chk("y_ex_sample_beats_init", lpf_y_ex, 32'h178);
        drain();

        // Reset in the middle of WAIT
        issue(32'h500, 32'h8000, 32'h0, 1'b0);
        void'(exp_q.pop_back());
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_m_valid", 32'(m_valid), 32'd0);
        chk("post_rst_lpf_sta", 32'(lpf_sta), 32'd0);
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);
        chk("post_rst_y_state", lpf_y_ex, 32'd0);
        issue(32'h100, 32'h8000, 32'h80, 1'b0);
        drain();

        // cfg_k change while busy
        issue(32'h280, 32'h8000, 32'h180, 1'b0);
        step();
        cfg_k = 32'h4000;
        @(negedge clk);
        chk("k_held_wait", lpf_k, 32'h8000);
        drain();
        issue(32'h580, 32'h4000, 32'h280, 1'b0);
        @(negedge clk);
        chk("k_next_op", lpf_k, 32'h4000);
        drain();

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
